// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, state encodings and record encoder for the calculator UART path
package calc_pkg;

   localparam int RECORD_BYTES = 4;

   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_E     = 8'h45;
   localparam logic [7:0] CH_R     = 8'h52;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;

   // Per-byte serializer phases: start bit, 8 data bits, stop bit
   typedef enum logic [1:0] {
      BIT_IDLE  = 2'd0,
      BIT_START = 2'd1,
      BIT_DATA  = 2'd2,
      BIT_STOP  = 2'd3
   } bit_state_e;

   // Record sequencer: FINISH is the one-cycle done slot after the last stop bit
   typedef enum logic [1:0] {
      REC_IDLE   = 2'd0,
      REC_SEND   = 2'd1,
      REC_FINISH = 2'd2
   } rec_state_e;

   // Byte idx of the 4-byte ASCII record for a captured result
   function automatic logic [7:0] record_byte(input logic signed [3:0] x,
                                              input logic              failed,
                                              input logic [1:0]        idx);
      logic [4:0] w_ext;
      logic [4:0] w_mag;
      logic [7:0] w_digit;
      // 5-bit magnitude so that -8 yields 8 instead of wrapping
      w_ext   = {x[3], x};
      w_mag   = x[3] ? (5'd0 - w_ext) : w_ext;
      w_digit = CH_ZERO + {3'b000, w_mag};
      case (idx)
         2'd0:    record_byte = failed ? CH_E : (x[3] ? CH_MINUS : CH_PLUS);
         2'd1:    record_byte = failed ? CH_R : w_digit;
         2'd2:    record_byte = CH_CR;
         default: record_byte = CH_LF;
      endcase
   endfunction

endpackage

// File: rtl/newton_result_tx_if.sv
// rtl/newton_result_tx_if.sv - solver result input and UART status/line bundle
interface newton_result_tx_if;
   logic              result_valid;
   logic signed [3:0] X_in;
   logic              failed_in;
   logic              tx;
   logic              busy;
   logic              done;
   logic              overrun;

   // Solver side
   modport master (
      output result_valid, X_in, failed_in,
      input  tx, busy, done, overrun
   );

   // Transmitter side
   modport slave (
      input  result_valid, X_in, failed_in,
      output tx, busy, done, overrun
   );
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serializer for one byte, back-to-back capable
module uart_tx_byte
   import calc_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_byte_done
);

   localparam int             CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   bit_state_e    r_state, w_state_nxt;
   logic [CW-1:0] r_baud, w_baud_nxt;
   logic [2:0]    r_bit_idx, w_bit_idx_nxt;
   logic          r_tx, w_tx_nxt;
   logic          w_bit_end;
   logic [2:0]    w_bit_inc;

   assign w_bit_end = (r_baud == BAUD_LAST);
   assign w_bit_inc = r_bit_idx + 3'd1;
   assign o_tx      = r_tx;

   // State, baud counter, bit index and line register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= BIT_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   // Next-state logic; i_data must stay stable until o_byte_done, and a start
   // during the last stop cycle chains the next byte with no idle gap
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud + CW'(1);
      w_bit_idx_nxt = r_bit_idx;
      w_tx_nxt      = r_tx;
      o_byte_done   = 1'b0;
      case (r_state)
         BIT_IDLE: begin
            w_baud_nxt = '0;
            w_tx_nxt   = 1'b1;
            if (i_start) begin
               w_state_nxt = BIT_START;
               w_tx_nxt    = 1'b0;
            end
         end
         BIT_START: begin
            if (w_bit_end) begin
               w_baud_nxt    = '0;
               w_state_nxt   = BIT_DATA;
               w_bit_idx_nxt = 3'd0;
               w_tx_nxt      = i_data[0];
            end
         end
         BIT_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt    = '0;
               w_bit_idx_nxt = w_bit_inc;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = BIT_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_tx_nxt    = i_data[w_bit_inc];
               end
            end
         end
         BIT_STOP: begin
            if (w_bit_end) begin
               w_baud_nxt  = '0;
               o_byte_done = 1'b1;
               if (i_start) begin
                  w_state_nxt = BIT_START;
                  w_tx_nxt    = 1'b0;
               end else begin
                  w_state_nxt = BIT_IDLE;
                  w_tx_nxt    = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = BIT_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/newton_result_tx.sv
// rtl/newton_result_tx.sv - captures one solver result and sends it as a 4-byte ASCII record
module newton_result_tx
   import calc_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 reset,
   newton_result_tx_if.slave    bus
);

   rec_state_e        r_state, w_state_nxt;
   logic [1:0]        r_byte_idx;
   logic signed [3:0] r_x;
   logic              r_failed;
   logic              r_overrun;

   logic       w_accept;
   logic       w_last_byte;
   logic       w_next_byte;
   logic       w_start;
   logic       w_byte_done;
   logic       w_tx;
   logic [7:0] w_data;

   assign w_accept    = bus.result_valid && (r_state == REC_IDLE);
   assign w_last_byte = (r_byte_idx == 2'(RECORD_BYTES - 1));
   assign w_next_byte = (r_state == REC_SEND) && w_byte_done && !w_last_byte;
   // The first start bit goes out on the edge that accepts the result
   assign w_start     = w_accept || w_next_byte;
   assign w_data      = record_byte(r_x, r_failed, r_byte_idx);

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk         (clk),
      .reset       (reset),
      .i_start     (w_start),
      .i_data      (w_data),
      .o_tx        (w_tx),
      .o_byte_done (w_byte_done)
   );

   // Record sequencer state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= REC_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Record sequencer next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         REC_IDLE:   if (bus.result_valid) w_state_nxt = REC_SEND;
         REC_SEND:   if (w_byte_done && w_last_byte) w_state_nxt = REC_FINISH;
         REC_FINISH: w_state_nxt = REC_IDLE;
         default:    w_state_nxt = REC_IDLE;
      endcase
   end

   // Result capture, byte index and sticky overrun (set by any dropped strobe)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_idx <= '0;
         r_x        <= '0;
         r_failed   <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_x        <= bus.X_in;
            r_failed   <= bus.failed_in;
            r_byte_idx <= '0;
         end else if (w_next_byte) begin
            r_byte_idx <= r_byte_idx + 2'd1;
         end
         if (bus.result_valid && !w_accept) r_overrun <= 1'b1;
      end
   end

   assign bus.tx      = w_tx;
   assign bus.busy    = (r_state == REC_SEND);
   assign bus.done    = (r_state == REC_FINISH);
   assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_newton_result_tx.sv
// tb/tb_newton_result_tx.sv - scoreboard bench for newton_result_tx at 4 clocks per bit
module tb_newton_result_tx;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   newton_result_tx_if bus();

   newton_result_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] exp_q[$];
   int         done_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Byte monitor: locks on the first low cycle of a start bit, samples one cycle into each bit
   logic       mon_active = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_sh = 8'h00;
   logic [7:0] exp_b;
   always @(negedge clk) begin
      if (reset) begin
         mon_active = 1'b0;
         mon_cnt    = 0;
      end else if (!mon_active) begin
         if (bus.tx == 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % CPB == 0) begin
            if (mon_cnt / CPB <= 8) begin
               mon_sh[mon_cnt / CPB - 1] = bus.tx;
            end else begin
               chk_bit("stop_bit", bus.tx, 1'b1);
               mon_active = 1'b0;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got 0x%02h expected none", mon_sh);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk_byte("tx_byte", mon_sh, exp_b);
               end
            end
         end
      end
   end

   // Done monitor: pulse timing against the acceptance cycle recorded by the stimulus
   int exp_c;
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         chk_bit("busy_at_done", bus.busy, 1'b0);
         if (done_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            exp_c = done_q.pop_front();
            chk_int("done_cycle", cyc, exp_c);
         end
      end
   end

   task automatic send(input logic [3:0] x, input logic f, input logic accept,
                       input logic [7:0] b0, input logic [7:0] b1);
      @(negedge clk);
      bus.result_valid = 1'b1;
      bus.X_in         = x;
      bus.failed_in    = f;
      if (accept) begin
         exp_q.push_back(b0);
         exp_q.push_back(b1);
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         done_q.push_back(cyc + 161);
      end
      @(negedge clk);
      bus.result_valid = 1'b0;
      bus.X_in         = 4'b0000;
      bus.failed_in    = 1'b0;
      if (accept) begin
         chk_bit("start_bit_after_accept", bus.tx, 1'b0);
         chk_bit("busy_after_accept", bus.busy, 1'b1);
      end else begin
         chk_bit("overrun_set", bus.overrun, 1'b1);
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (bus.done !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got no done expected done within 400 cycles");
      end
   endtask

   initial begin
      bus.result_valid = 1'b0;
      bus.X_in         = 4'b0000;
      bus.failed_in    = 1'b0;
      reset            = 1'b1;
      repeat (3) @(negedge clk);
      chk_bit("reset_tx", bus.tx, 1'b1);
      chk_bit("reset_busy", bus.busy, 1'b0);
      chk_bit("reset_done", bus.done, 1'b0);
      chk_bit("reset_overrun", bus.overrun, 1'b0);
      reset = 1'b0;

      send(4'b0011, 1'b0, 1'b1, 8'h2B, 8'h33);
      wait_done();
      chk_bit("overrun_clear", bus.overrun, 1'b0);
      repeat (3) @(negedge clk);

      send(4'b1000, 1'b0, 1'b1, 8'h2D, 8'h38);
      wait_done();
      repeat (2) @(negedge clk);
      send(4'b0000, 1'b0, 1'b1, 8'h2B, 8'h30);
      wait_done();
      repeat (2) @(negedge clk);
      send(4'b0101, 1'b1, 1'b1, 8'h45, 8'h52);
      wait_done();
      repeat (2) @(negedge clk);

      send(4'b0001, 1'b0, 1'b1, 8'h2B, 8'h31);
      repeat (18) @(negedge clk);
      send(4'b0111, 1'b0, 1'b0, 8'h00, 8'h00);
      wait_done();
      chk_bit("overrun_sticky_at_done", bus.overrun, 1'b1);
      send(4'b1111, 1'b0, 1'b1, 8'h2D, 8'h31);
      wait_done();
      chk_bit("overrun_sticky_later", bus.overrun, 1'b1);
      repeat (2) @(negedge clk);

      send(4'b0010, 1'b0, 1'b1, 8'h2B, 8'h32);
      repeat (56) @(negedge clk);
      chk_bit("tx_low_before_reset", bus.tx, 1'b0);
      reset = 1'b1;
      exp_q.delete();
      done_q.delete();
      @(negedge clk);
      chk_bit("midrec_reset_tx", bus.tx, 1'b1);
      chk_bit("midrec_reset_busy", bus.busy, 1'b0);
      chk_bit("midrec_reset_overrun", bus.overrun, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      send(4'b1101, 1'b0, 1'b1, 8'h2D, 8'h33);
      wait_done();
      send(4'b0110, 1'b0, 1'b1, 8'h2B, 8'h36);
      chk_bit("overrun_b2b", bus.overrun, 1'b0);
      wait_done();

      bus.result_valid = 1'b1;
      bus.X_in         = 4'b0100;
      @(negedge clk);
      bus.result_valid = 1'b0;
      bus.X_in         = 4'b0000;
      chk_bit("overrun_done_cycle", bus.overrun, 1'b1);
      chk_bit("busy_done_cycle_drop", bus.busy, 1'b0);
      chk_bit("tx_done_cycle_drop", bus.tx, 1'b1);
      send(4'b0100, 1'b0, 1'b1, 8'h2B, 8'h34);
      wait_done();

      repeat (5) @(negedge clk);
      chk_int("bytes_outstanding", exp_q.size(), 0);
      chk_int("done_outstanding", done_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/newton_result_tx.md
# newton_result_tx

- Transmit side of the UART calculator path: takes one result from the Newton solver (signed 4-bit root, failure flag, valid strobe) and sends it back to the host.
- Encoding is a fixed 4-byte ASCII record over 8N1 serial.
- Sits between the solver outputs and the board TX pin, mirroring the receive path that feeds the solver coefficients.
- Buffers exactly one result and reports busy, done and overrun.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- result_valid  input  1  one-cycle strobe: X_in/failed_in are valid
- X_in  input  4  signed root from solver, range −8..7
- failed_in  input  1  solver reported bot == 0
- tx  output  1  UART serial line, idle high
- busy  output  1  high from acceptance until the last stop bit completes
- done  output  1  one-cycle pulse after the record's final stop bit
- overrun  output  1  sticky; set when result_valid arrives while busy

## Operation
- Acceptance:
  - result_valid with busy = 0 captures X_in and failed_in into internal registers.
  - Acceptance and busy = 1 take effect on the next edge.
  - result_valid while busy = 1 is dropped, sets overrun, and leaves the record in flight untouched.
- Record encoding, always 4 bytes, sent in order:
  - failed_in = 1: 'E' (0x45), 'R' (0x52), CR (0x0D), LF (0x0A). X_in is ignored.
  - failed_in = 0: sign byte, digit byte, CR, LF.
  - Sign byte: '-' (0x2D) if X_in[3] = 1, else '+' (0x2B).
  - Digit byte: '0' + |X_in|. Magnitude is computed in 5 bits so −8 gives '8' (0x38) without overflow. 0 gives "+0".
- Byte framing:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- No idle gap between bytes: the next start bit begins on the cycle after the previous stop bit ends.
- FSM states: IDLE → START → DATA → STOP → (byte_idx < 3 ? START : FINISH) → IDLE.
  - FINISH lasts one cycle, asserts done, clears busy.
  - byte_idx is a 2-bit counter. bit_idx is 3-bit and wraps 7→0 on the exit from DATA.
  - The baud counter counts 0..CLKS_PER_BIT−1 and resets on every bit boundary.
- Reset values: tx = 1, busy = 0, done = 0, overrun = 0, FSM = IDLE, all counters 0.
- Reset mid-record aborts immediately: tx returns high on the next edge and no partial byte resumes.
- overrun clears only on reset.
- A result_valid that coincides with the done cycle is dropped and sets overrun. The cycle after done is the first accepting cycle.

## Timing
- Acceptance edge at cycle T: tx falls (start bit) at T+1.
- Bit k of byte n occupies cycles T+1 + (n·10 + k)·CLKS_PER_BIT through the next CLKS_PER_BIT−1 cycles (k = 0 start, 1..8 data, 9 stop).
- Last stop bit ends at T + 40·CLKS_PER_BIT.
- done is high at cycle T + 40·CLKS_PER_BIT + 1; busy is low from the same cycle.
- Throughput: one record per 40·CLKS_PER_BIT + 2 cycles.
- tx is a registered output with no combinational path from any input.

## Structure
- Shared package calc_pkg holds:
  - ASCII constants (CH_PLUS, CH_MINUS, CH_ZERO, CH_E, CH_R, CH_CR, CH_LF).
  - The FSM state encoding.
  - A RECORD_BYTES = 4 constant.
- Sub-module uart_tx_byte:
  - Serializer for one byte, parameterised by CLKS_PER_BIT.
  - Handshake: start/data_in in, tx/byte_done out.
- The top level owns capture, encoding, byte sequencing, and the busy/done/overrun flags.
- Target size: 150–250 lines total.

## Test plan
All scenarios run with CLKS_PER_BIT = 4.
- Positive root: X_in = 4'sb0011 (+3), failed_in = 0 → tx decodes to 0x2B 0x33 0x0D 0x0A; done exactly 161 cycles after the acceptance edge.
- Most negative root: X_in = 4'sb1000 (−8) → bytes 0x2D 0x38 0x0D 0x0A; X_in = 0 → 0x2B 0x30 0x0D 0x0A.
- Failure record: failed_in = 1 with X_in = 5 → bytes 0x45 0x52 0x0D 0x0A; X_in is not reflected in the record.
- Overrun: second result_valid 20 cycles into a record → the first record is unchanged, overrun = 1 and stays high after done; the next result after done transmits normally.
- Reset mid-record: reset during byte 1, bit 4 → next edge tx = 1, busy = 0, overrun = 0; a new result then gives a clean 4-byte record.
- Back-to-back: result_valid on the cycle after done → accepted, start bit on the following cycle, overrun stays 0.
